yx_processor: RTL and testbench

- Route-computation unit for one router in a 2-D mesh NoC.
- Compares a packet header's destination coordinate with the local router's coordinate and picks the output port using dimension-ordered YX routing: resolve Y first, then X.
- Result is registered, with one cycle of latency, and feeds the router's crossbar/arbiter select.

---
 rtl/yx_processor_if.sv | 49 ++++
 rtl/yx_processor.sv | 108 ++++++++++
 tb/tb_yx_processor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/yx_processor_if.sv
// rtl/yx_processor_if.sv - request/result bundle between a router header stage and its YX route unit
//
// Purpose : groups the route-request inputs and registered route results of
//           yx_processor so they travel as one port.
// Signals : valid_i           - header address presented, request a route
//           yx_addr_header_i  - destination address {Y, X}
//           yx_addr_router_i  - this router's address {Y, X}, quasi-static
//           yx_addr_o         - registered output-port select
//           valid_o           - yx_addr_o holds a fresh result
//           route_err_o       - destination outside the mesh (YX_BOUND_CHECK_EN only)
// Modports: master drives requests and observes results; slave is the route unit.
// Macro   : YX_BOUND_CHECK_EN adds route_err_o.

interface yx_processor_if #(
  parameter int COORD_W = 4
);

  logic                   valid_i;
  logic [2*COORD_W-1:0]   yx_addr_header_i;
  logic [2*COORD_W-1:0]   yx_addr_router_i;
  logic [2:0]             yx_addr_o;
  logic                   valid_o;
`ifdef YX_BOUND_CHECK_EN
  logic                   route_err_o;
`endif

`ifdef YX_BOUND_CHECK_EN
  modport master (
    output valid_i, yx_addr_header_i, yx_addr_router_i,
    input  yx_addr_o, valid_o, route_err_o
  );

  modport slave (
    input  valid_i, yx_addr_header_i, yx_addr_router_i,
    output yx_addr_o, valid_o, route_err_o
  );
`else
  modport master (
    output valid_i, yx_addr_header_i, yx_addr_router_i,
    input  yx_addr_o, valid_o
  );

  modport slave (
    input  valid_i, yx_addr_header_i, yx_addr_router_i,
    output yx_addr_o, valid_o
  );
`endif

endinterface

// File: rtl/yx_processor.sv
// rtl/yx_processor.sv - YX dimension-ordered route computation for one 2-D mesh router
//
// Purpose : compares a packet's destination coordinate with the local router
//           coordinate, resolving Y first and then X, and registers the chosen
//           output port with one cycle of latency.
// Ports   : clk_i  - clock, rising-edge
//           rst_ni - asynchronous active-low reset
//           bus    - yx_processor_if.slave (valid_i, yx_addr_header_i,
//                    yx_addr_router_i, yx_addr_o, valid_o[, route_err_o])
// Encoding: 0 LOCAL, 1 NORTH, 2 SOUTH, 3 EAST, 4 WEST, 7 ERROR
// Macro   : YX_BOUND_CHECK_EN - flag destinations outside MESH_X x MESH_Y with
//           port 7 and route_err_o.

module yx_processor #(
  parameter int COORD_W = 4,
  parameter int MESH_X  = 4,
  parameter int MESH_Y  = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  yx_processor_if.slave bus
);

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_EAST  = 3'd3,
    PORT_WEST  = 3'd4,
    PORT_ERROR = 3'd7
  } port_e;

  logic [COORD_W-1:0] dst_x, dst_y, rtr_x, rtr_y;
  port_e              route_d;
  logic [2:0]         yx_addr_q;
  logic               valid_q;

  assign dst_x = bus.yx_addr_header_i[COORD_W-1:0];
  assign dst_y = bus.yx_addr_header_i[2*COORD_W-1:COORD_W];
  assign rtr_x = bus.yx_addr_router_i[COORD_W-1:0];
  assign rtr_y = bus.yx_addr_router_i[2*COORD_W-1:COORD_W];

  // A mesh wider or taller than the coordinate space leaves columns/rows that
  // no header can address; the named block marks such a build in the hierarchy.
  if ((MESH_X > (1 << COORD_W)) || (MESH_Y > (1 << COORD_W))) begin : g_mesh_exceeds_coord_range
  end

`ifdef YX_BOUND_CHECK_EN
  // One extra bit so a mesh dimension equal to 2**COORD_W still compares correctly.
  localparam logic [COORD_W:0] MESH_X_LIM = (COORD_W+1)'(MESH_X);
  localparam logic [COORD_W:0] MESH_Y_LIM = (COORD_W+1)'(MESH_Y);

  logic route_err_d;
  logic route_err_q;

  assign route_err_d = ({1'b0, dst_x} >= MESH_X_LIM) || ({1'b0, dst_y} >= MESH_Y_LIM);
`endif

  // Y is resolved before X so packets never turn from X back into Y,
  // which keeps the routing function deadlock-free on a mesh.
  always_comb begin
    route_d = PORT_LOCAL;
    if (dst_y > rtr_y) begin
      route_d = PORT_NORTH;
    end else if (dst_y < rtr_y) begin
      route_d = PORT_SOUTH;
    end else if (dst_x > rtr_x) begin
      route_d = PORT_EAST;
    end else if (dst_x < rtr_x) begin
      route_d = PORT_WEST;
    end
`ifdef YX_BOUND_CHECK_EN
    if (route_err_d) begin
      route_d = PORT_ERROR;
    end
`endif
  end

  // The select only moves on a request so the crossbar keeps its last route
  // while the header stage is idle; valid_o marks which cycles are fresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yx_addr_q <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        yx_addr_q <= route_d;
      end
    end
  end

`ifdef YX_BOUND_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      route_err_q <= 1'b0;
    end else if (bus.valid_i) begin
      route_err_q <= route_err_d;
    end
  end

  assign bus.route_err_o = route_err_q;
`endif

  assign bus.yx_addr_o = yx_addr_q;
  assign bus.valid_o   = valid_q;

endmodule

// File: tb/tb_yx_processor.sv
// tb/tb_yx_processor.sv - directed self-checking bench for yx_processor

module tb_yx_processor;

  logic clk_i;
  logic rst_ni;
  int   total;
  int   bad;

  yx_processor_if #(.COORD_W(4)) bus ();

  yx_processor #(
    .COORD_W(4),
    .MESH_X (4),
    .MESH_Y (4)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one request on the falling edge; return 1 ns after the capturing edge.
  task automatic send(input logic [7:0] router, input logic [7:0] header, input logic vld);
    @(negedge clk_i);
    bus.yx_addr_router_i = router;
    bus.yx_addr_header_i = header;
    bus.valid_i          = vld;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_ni               = 1'b0;
    bus.valid_i          = 1'b0;
    bus.yx_addr_header_i = 8'h00;
    bus.yx_addr_router_i = 8'h00;
    @(posedge clk_i);
    #1;
    total++;
    if (bus.yx_addr_o !== 3'd0) begin
      bad++;
      $display("FAIL reset_addr: got %0d want 0", bus.yx_addr_o);
    end
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", bus.valid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      total++;
      if (bus.yx_addr_o !== 3'd0 || bus.valid_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset[%0d]: got addr=%0d valid=%b want addr=0 valid=0",
                 i, bus.yx_addr_o, bus.valid_o);
      end
    end
  endtask

  task automatic test_async_reset;
    send(8'h00, 8'h20, 1'b1);
    total++;
    if (bus.yx_addr_o !== 3'd1 || bus.valid_o !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_route: got addr=%0d valid=%b want addr=1 valid=1",
               bus.yx_addr_o, bus.valid_o);
    end
    // Mid-cycle, well away from any edge: outputs must clear without a clock.
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (bus.yx_addr_o !== 3'd0 || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got addr=%0d valid=%b want addr=0 valid=0",
               bus.yx_addr_o, bus.valid_o);
    end
    // Pending request swallowed by a reset that covers its capturing edge.
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.yx_addr_router_i = 8'h00;
    bus.yx_addr_header_i = 8'h20;
    bus.valid_i          = 1'b1;
    #2;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni      = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    total++;
    if (bus.yx_addr_o !== 3'd0 || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL pending_dropped: got addr=%0d valid=%b want addr=0 valid=0",
               bus.yx_addr_o, bus.valid_o);
    end
    send(8'h20, 8'h00, 1'b1);
    total++;
    if (bus.yx_addr_o !== 3'd2 || bus.valid_o !== 1'b1) begin
      bad++;
      $display("FAIL first_after_release: got addr=%0d valid=%b want addr=2 valid=1",
               bus.yx_addr_o, bus.valid_o);
    end
  endtask

  task automatic run_table(input string name, input logic [7:0] rtr[], input logic [7:0] hdr[],
                           input logic [2:0] exp[]);
    for (int i = 0; i < rtr.size(); i++) begin
      send(rtr[i], hdr[i], 1'b1);
      total++;
      if (bus.yx_addr_o !== exp[i] || bus.valid_o !== 1'b1) begin
        bad++;
        $display("FAIL %s[%0d] rtr=%h hdr=%h: got addr=%0d valid=%b want addr=%0d valid=1",
                 name, i, rtr[i], hdr[i], bus.yx_addr_o, bus.valid_o, exp[i]);
      end
    end
  endtask

  task automatic test_y_resolution;
    logic [7:0] rtr[] = '{8'h20, 8'h00, 8'h33, 8'h00};
    logic [7:0] hdr[] = '{8'h00, 8'h20, 8'h00, 8'h33};
    logic [2:0] exp[] = '{3'd2,  3'd1,  3'd2,  3'd1};
    run_table("y_resolution", rtr, hdr, exp);
  endtask

  task automatic test_y_priority;
    logic [7:0] rtr[] = '{8'h12, 8'h21, 8'hF0, 8'h0F};
    logic [7:0] hdr[] = '{8'h21, 8'h12, 8'hFF, 8'hF0};
    logic [2:0] exp[] = '{3'd1,  3'd2,  3'd3,  3'd1};
    run_table("y_priority", rtr, hdr, exp);
  endtask

  task automatic test_x_local;
    logic [7:0] rtr[] = '{8'h11, 8'h13, 8'h11, 8'h22, 8'h23};
    logic [7:0] hdr[] = '{8'h13, 8'h11, 8'h11, 8'h22, 8'h22};
    logic [2:0] exp[] = '{3'd3,  3'd4,  3'd0,  3'd0,  3'd4};
    run_table("x_local", rtr, hdr, exp);
  endtask

  task automatic test_back_to_back;
    logic [7:0] hdr[] = '{8'h31, 8'h01, 8'h14};
    logic [2:0] exp[] = '{3'd1,  3'd2,  3'd3};
    @(negedge clk_i);
    bus.yx_addr_router_i = 8'h11;
    bus.yx_addr_header_i = hdr[0];
    bus.valid_i          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      total++;
      if (bus.yx_addr_o !== exp[i] || bus.valid_o !== 1'b1) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got addr=%0d valid=%b want addr=%0d valid=1",
                 i, bus.yx_addr_o, bus.valid_o, exp[i]);
      end
      @(negedge clk_i);
      if (i < 2) bus.yx_addr_header_i = hdr[i+1];
    end
    // Idle with a moving header: select holds EAST, valid drops.
    bus.valid_i          = 1'b0;
    bus.yx_addr_header_i = 8'h10;
    @(posedge clk_i);
    #1;
    total++;
    if (bus.yx_addr_o !== 3'd3 || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_0: got addr=%0d valid=%b want addr=3 valid=0",
               bus.yx_addr_o, bus.valid_o);
    end
    send(8'h11, 8'h51, 1'b0);
    total++;
    if (bus.yx_addr_o !== 3'd3 || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_1: got addr=%0d valid=%b want addr=3 valid=0",
               bus.yx_addr_o, bus.valid_o);
    end
  endtask

`ifdef YX_BOUND_CHECK_EN
  task automatic test_bound_check;
    send(8'h00, 8'h05, 1'b1);
    total++;
    if (bus.yx_addr_o !== 3'd7 || bus.route_err_o !== 1'b1) begin
      bad++;
      $display("FAIL bound_x_out: got addr=%0d err=%b want addr=7 err=1",
               bus.yx_addr_o, bus.route_err_o);
    end
    send(8'h00, 8'h03, 1'b0);
    total++;
    if (bus.yx_addr_o !== 3'd7 || bus.route_err_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bound_hold: got addr=%0d err=%b valid=%b want addr=7 err=1 valid=0",
               bus.yx_addr_o, bus.route_err_o, bus.valid_o);
    end
    send(8'h00, 8'h03, 1'b1);
    total++;
    if (bus.yx_addr_o !== 3'd3 || bus.route_err_o !== 1'b0) begin
      bad++;
      $display("FAIL bound_in: got addr=%0d err=%b want addr=3 err=0",
               bus.yx_addr_o, bus.route_err_o);
    end
    send(8'h00, 8'h40, 1'b1);
    total++;
    if (bus.yx_addr_o !== 3'd7 || bus.route_err_o !== 1'b1) begin
      bad++;
      $display("FAIL bound_y_out: got addr=%0d err=%b want addr=7 err=1",
               bus.yx_addr_o, bus.route_err_o);
    end
  endtask
`else
  task automatic test_full_width;
    logic [7:0] rtr[] = '{8'h00, 8'h00, 8'hFF};
    logic [7:0] hdr[] = '{8'h05, 8'hF0, 8'h0F};
    logic [2:0] exp[] = '{3'd3,  3'd1,  3'd2};
    run_table("full_width", rtr, hdr, exp);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_async_reset();
    test_y_resolution();
    test_y_priority();
    test_x_local();
    test_back_to_back();
`ifdef YX_BOUND_CHECK_EN
    test_bound_check();
`else
    test_full_width();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
